// File: rtl/jk_cnt_pkg.sv
// Shared definitions for the JK excitation counter: direction encoding
// and the clamp applied to parallel-load values.
package jk_cnt_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  // Values at or above the modulus load as the top of the count range.
  function automatic int unsigned clamp_load(input int unsigned val,
                                             input int unsigned modulus);
    return (val >= modulus) ? (modulus - 1) : val;
  endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// One JK flip-flop state bit with synchronous active-high reset.
module jk_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK update: 00 hold, 01 clear, 10 set, 11 toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_excitation_counter.sv
// Modulo up/down counter built from JK cells; exposes the per-bit J/K
// excitation for the transition taken at the next edge.
// Build option: define JK_CNT_SATURATE_EN to hold at the end value
// instead of wrapping.
module jk_excitation_counter
  import jk_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc
);

`ifdef JK_CNT_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] load_clamped;
  logic             at_end;

  // Next-state selection: rst > load > en, otherwise hold.
  // During rst n follows q so j/k stay zero; the cells clear on rst themselves.
  always_comb begin
    load_clamped = WIDTH'(clamp_load(32'(load_val), MODULUS));
    at_end       = (up_dn == DIR_UP) ? (q == TOP) : (q == '0);
    n            = q;
    if (rst) begin
      n = q;
    end else if (load) begin
      n = load_clamped;
    end else if (en) begin
      if (at_end) begin
        if (SATURATE)
          n = q;
        else
          n = (up_dn == DIR_UP) ? '0 : TOP;
      end else begin
        n = (up_dn == DIR_UP) ? q + 1'b1 : q - 1'b1;
      end
    end
  end

  // Excitation and terminal count derived from q and the chosen next state.
  always_comb begin
    j  = ~q & n;
    k  = q & ~n;
    tc = ~rst & en & ~load & at_end;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_bit_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Directed testbench for jk_excitation_counter (default WIDTH=4, MODULUS=10).
module tb_jk_excitation_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] q, j, k;
  logic       tc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_excitation_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .j        (j),
    .k        (k),
    .tc       (tc)
  );

  // Advance one edge; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (q !== 4'd0 || j !== 4'd0 || k !== 4'd0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: q=%h j=%b k=%b tc=%b, want q=0 j=0000 k=0000 tc=0",
                 c, q, j, k, tc);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_hold();
    logic [3:0] held;
    en = 1'b0; load = 1'b0; #1;
    held = q;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (j !== 4'd0 || k !== 4'd0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL hold_jk: j=%b k=%b tc=%b, want 0000 0000 0", j, k, tc);
      end
      tick();
      checks++;
      if (q !== held) begin
        errors++;
        $display("FAIL hold_q: q=%h, want %h", q, held);
      end
    end
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q, exp_n, exp_j, exp_k;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; up_dn = 1'b1; load = 1'b0; #1;
    for (int i = 0; i < 12; i++) begin
      exp_q = 4'(i % 10);
      exp_n = 4'((i + 1) % 10);
      exp_j = ~exp_q & exp_n;
      exp_k = exp_q & ~exp_n;
      checks++;
      if (q !== exp_q || tc !== (exp_q == 4'd9) || j !== exp_j || k !== exp_k) begin
        errors++;
        $display("FAIL count_up step%0d: q=%h tc=%b j=%b k=%b, want q=%h tc=%b j=%b k=%b",
                 i, q, tc, j, k, exp_q, (exp_q == 4'd9), exp_j, exp_k);
      end
      tick();
    end
  endtask

  task automatic test_count_down();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; up_dn = 1'b0; load = 1'b0; #1;
    checks++;
    if (tc !== 1'b1 || j !== 4'b1001 || k !== 4'b0000) begin
      errors++;
      $display("FAIL down_at0: tc=%b j=%b k=%b, want tc=1 j=1001 k=0000", tc, j, k);
    end
    tick();
    checks++;
    if (q !== 4'd9 || tc !== 1'b0 || j !== 4'b0000 || k !== 4'b0001) begin
      errors++;
      $display("FAIL down_wrap: q=%h tc=%b j=%b k=%b, want q=9 tc=0 j=0000 k=0001",
               q, tc, j, k);
    end
    tick();
    checks++;
    if (q !== 4'd8) begin
      errors++;
      $display("FAIL down_step: q=%h, want 8", q);
    end
  endtask

  task automatic test_load();
    logic [3:0] vals [5] = '{4'd13, 4'd5, 4'd15, 4'd10, 4'd9};
    logic [3:0] exps [5] = '{4'd9,  4'd5, 4'd9,  4'd9,  4'd9};
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; load_val = vals[i]; #1;
      checks++;
      if (tc !== 1'b0) begin
        errors++;
        $display("FAIL load_tc val=%0d: tc=%b, want 0", vals[i], tc);
      end
      tick();
      checks++;
      if (q !== exps[i]) begin
        errors++;
        $display("FAIL load val=%0d: q=%h, want %h", vals[i], q, exps[i]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_direction_change();
    load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
    en = 1'b1; up_dn = 1'b1; tick();
    checks++;
    if (q !== 4'd6) begin errors++; $display("FAIL dir_up: q=%h, want 6", q); end
    up_dn = 1'b0; tick();
    checks++;
    if (q !== 4'd5) begin errors++; $display("FAIL dir_dn: q=%h, want 5", q); end
    up_dn = 1'b1; tick();
    checks++;
    if (q !== 4'd6) begin errors++; $display("FAIL dir_up2: q=%h, want 6", q); end
    load = 1'b1; load_val = 4'd9; tick(); load = 1'b0;
    up_dn = 1'b0; #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL dir_tc9dn: tc=%b, want 0", tc); end
    tick();
    checks++;
    if (q !== 4'd8) begin errors++; $display("FAIL dir_9dn: q=%h, want 8", q); end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] pq, pj, pk, exp_next;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; up_dn = 1'b1; load = 1'b0; #1;
    for (int i = 0; i < 6; i++) begin
      pq = q; pj = j; pk = k;
      checks++;
      if ((pj & pk) !== 4'd0) begin
        errors++;
        $display("FAIL jk_both step%0d: j=%b k=%b, want j&k=0000", i, pj, pk);
      end
      tick();
      exp_next = (pj & ~pq) | (~pk & pq);
      checks++;
      if (q !== exp_next || q !== 4'(i + 1)) begin
        errors++;
        $display("FAIL jk_eq step%0d: q=%h, want %h (count %0d)", i, q, exp_next, i + 1);
      end
    end
    rst = 1'b1; #1;
    checks++;
    if (j !== 4'd0 || k !== 4'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_jk: j=%b k=%b tc=%b, want 0000 0000 0", j, k, tc);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL mid_rst_q: q=%h, want 0", q); end
    tick();
    checks++;
    if (q !== 4'd1) begin errors++; $display("FAIL mid_rst_resume: q=%h, want 1", q); end
  endtask

`ifdef JK_CNT_SATURATE_EN
  task automatic test_saturate();
    load = 1'b1; load_val = 4'd8; tick(); load = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== 4'd9 || j !== 4'd0 || k !== 4'd0 || tc !== 1'b1) begin
        errors++;
        $display("FAIL saturate step%0d: q=%h j=%b k=%b tc=%b, want q=9 j=0000 k=0000 tc=1",
                 i, q, j, k, tc);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hold();
`ifdef JK_CNT_SATURATE_EN
    test_saturate();
`else
    test_count_up();
    test_count_down();
`endif
    test_load();
    test_direction_change();
    test_reset_mid_count();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
